next_level_req_queue: RTL and testbench

Request queue between the L1 caches and the next-level cache/memory model. The instruction cache and the data cache each present at most one line request per clock. This block merges the two streams into one in-order FIFO and issues entries downstream over a valid/ready handshake. It also keeps accepted/dropped request counters for the statistics module.

---
 rtl/next_level_req_queue.sv | 147 ++++++++++++++
 tb/tb_next_level_req_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/next_level_req_queue.sv
// Merges instruction- and data-cache line requests into one in-order FIFO toward the next level.
// Optional read coalescing against the queue tail is enabled by defining NLQ_MERGE_EN.
module next_level_req_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ic_add_in,
    input  logic [1:0]        ic_cmd_in,
    input  logic [ADDR_W-1:0] dc_add_in,
    input  logic [1:0]        dc_cmd_in,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_add_out,
    output logic [1:0]        mem_cmd_out,
    input  logic              mem_ready,
    output logic [31:0]       reqs,
    output logic [31:0]       drops,
    output logic [31:0]       merges
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WB = 2'b10;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [1:0]        cmd_q  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   reqs_q;
    logic [31:0]   drops_q;

    logic          ic_req;
    logic          dc_req;
    logic          pop;
    logic [CW-1:0] free;
    logic          ic_merge;
    logic          dc_merge;
    logic          ic_want;
    logic          dc_want;
    logic          ic_push;
    logic          dc_push;
    logic [1:0]    n_push;
    logic [1:0]    n_drop;
    logic [PW-1:0] dc_slot;

`ifdef NLQ_MERGE_EN
    logic [31:0]       merges_q;
    logic [1:0]        n_merge;
    logic [PW-1:0]     tail_idx;
    logic              tail_hit_ic;
    logic              tail_hit_dc;
    logic              tail_live;
`endif

    always_comb begin
        ic_req   = (ic_cmd_in == CMD_RD);
        dc_req   = (dc_cmd_in == CMD_RD) || (dc_cmd_in == CMD_WB);
        pop      = mem_valid & mem_ready;
        free     = CW'(DEPTH) - count + CW'(pop);
        ic_merge = 1'b0;
        dc_merge = 1'b0;

`ifdef NLQ_MERGE_EN
        // The tail entry survives this edge unless it is the only entry and is being popped.
        tail_idx    = wr_ptr - PW'(1);
        tail_live   = (count - CW'(pop)) != '0;
        tail_hit_ic = tail_live && (cmd_q[tail_idx] == CMD_RD) && (addr_q[tail_idx] == ic_add_in);
        tail_hit_dc = tail_live && (cmd_q[tail_idx] == CMD_RD) && (addr_q[tail_idx] == dc_add_in);
        ic_merge    = ic_req && tail_hit_ic;
`endif

        ic_want = ic_req & ~ic_merge;
        ic_push = ic_want && (free != '0);

`ifdef NLQ_MERGE_EN
        // A DC read compares against the IC entry written this edge, otherwise against the tail.
        if (dc_cmd_in == CMD_RD) begin
            if (ic_push)
                dc_merge = (dc_add_in == ic_add_in);
            else
                dc_merge = tail_hit_dc;
        end
        n_merge = {1'b0, ic_merge} + {1'b0, dc_merge};
`endif

        dc_want = dc_req & ~dc_merge;
        dc_push = dc_want && (ic_push ? (free >= CW'(2)) : (free != '0));

        n_push  = {1'b0, ic_push} + {1'b0, dc_push};
        n_drop  = {1'b0, ic_want & ~ic_push} + {1'b0, dc_want & ~dc_push};
        dc_slot = wr_ptr + PW'(ic_push);
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (ic_push) begin
                addr_q[wr_ptr] <= ic_add_in;
                cmd_q[wr_ptr]  <= ic_cmd_in;
            end
            if (dc_push) begin
                addr_q[dc_slot] <= dc_add_in;
                cmd_q[dc_slot]  <= dc_cmd_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            reqs_q  <= '0;
            drops_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(n_push);
            rd_ptr  <= rd_ptr + PW'(pop);
            count   <= count + CW'(n_push) - CW'(pop);
            reqs_q  <= reqs_q + 32'(n_push);
            drops_q <= drops_q + 32'(n_drop);
        end
    end

`ifdef NLQ_MERGE_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            merges_q <= '0;
        else
            merges_q <= merges_q + 32'(n_merge);
    end
    assign merges = merges_q;
`else
    assign merges = 32'd0;
`endif

    assign mem_valid   = (count != '0);
    assign mem_add_out = mem_valid ? addr_q[rd_ptr] : '0;
    assign mem_cmd_out = mem_valid ? cmd_q[rd_ptr]  : 2'b00;
    assign reqs        = reqs_q;
    assign drops       = drops_q;

endmodule

// File: tb/tb_next_level_req_queue.sv
// Directed checks of next_level_req_queue: ordering, overflow, drain/wrap, reset, and read coalescing.
module tb_next_level_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] ic_add_in;
    logic [1:0]  ic_cmd_in;
    logic [25:0] dc_add_in;
    logic [1:0]  dc_cmd_in;
    logic        mem_valid;
    logic [25:0] mem_add_out;
    logic [1:0]  mem_cmd_out;
    logic        mem_ready;
    logic [31:0] reqs;
    logic [31:0] drops;
    logic [31:0] merges;

    int total = 0;
    int bad   = 0;

    next_level_req_queue #(.DEPTH(8), .ADDR_W(26)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_add_in(ic_add_in), .ic_cmd_in(ic_cmd_in),
        .dc_add_in(dc_add_in), .dc_cmd_in(dc_cmd_in),
        .mem_valid(mem_valid), .mem_add_out(mem_add_out), .mem_cmd_out(mem_cmd_out),
        .mem_ready(mem_ready),
        .reqs(reqs), .drops(drops), .merges(merges)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ic_cmd_in = 2'b00; ic_add_in = '0;
        dc_cmd_in = 2'b00; dc_add_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [25:0] exp_addr [9];

        idle_inputs();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid",  32'(mem_valid), 32'd0);
        chk("rst_addr",   32'(mem_add_out), 32'd0);
        chk("rst_cmd",    32'(mem_cmd_out), 32'd0);
        chk("rst_reqs",   reqs, 32'd0);
        chk("rst_drops",  drops, 32'd0);
        chk("rst_merges", merges, 32'd0);

        // single read with ready held high: visible right after the edge, gone one clock later
        mem_ready = 1'b1;
        ic_cmd_in = 2'b01; ic_add_in = 26'h000_0ABC;
        step();
        idle_inputs();
        chk("t1_valid", 32'(mem_valid), 32'd1);
        chk("t1_addr",  32'(mem_add_out), 32'h0ABC);
        chk("t1_cmd",   32'(mem_cmd_out), 32'd1);
        chk("t1_reqs",  reqs, 32'd1);
        step();
        chk("t1_gone",  32'(mem_valid), 32'd0);
        chk("t1_gone_addr", 32'(mem_add_out), 32'd0);

        // simultaneous IC read + DC write-back: IC first
        do_reset();
        ic_cmd_in = 2'b01; ic_add_in = 26'h10;
        dc_cmd_in = 2'b10; dc_add_in = 26'h20;
        step();
        idle_inputs();
        chk("t2_head_addr", 32'(mem_add_out), 32'h10);
        chk("t2_head_cmd",  32'(mem_cmd_out), 32'd1);
        step();
        chk("t2_hold_addr", 32'(mem_add_out), 32'h10);
        chk("t2_hold_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        step();
        chk("t2_second_addr", 32'(mem_add_out), 32'h20);
        chk("t2_second_cmd",  32'(mem_cmd_out), 32'd2);
        step();
        chk("t2_empty", 32'(mem_valid), 32'd0);
        chk("t2_reqs",  reqs, 32'd2);

        // fill, overflow with no pop, then overflow with pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ic_cmd_in = 2'b01; ic_add_in = 26'h100 + 26'(i);
            step();
        end
        chk("t3_fill_reqs", reqs, 32'd8);
        ic_cmd_in = 2'b01; ic_add_in = 26'h200;
        dc_cmd_in = 2'b01; dc_add_in = 26'h300;
        step();
        chk("t3_full_drops", drops, 32'd2);
        chk("t3_full_reqs",  reqs, 32'd8);
        chk("t3_full_head",  32'(mem_add_out), 32'h100);
        mem_ready = 1'b1;
        ic_cmd_in = 2'b01; ic_add_in = 26'h201;
        dc_cmd_in = 2'b10; dc_add_in = 26'h301;
        step();
        idle_inputs();
        chk("t3_pop_drops", drops, 32'd3);
        chk("t3_pop_reqs",  reqs, 32'd9);
        for (int i = 0; i < 7; i++) exp_addr[i] = 26'h101 + 26'(i);
        exp_addr[7] = 26'h201;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_drain%0d_valid", i), 32'(mem_valid), 32'd1);
            chk($sformatf("t3_drain%0d_addr", i), 32'(mem_add_out), 32'(exp_addr[i]));
            step();
        end
        chk("t3_drained", 32'(mem_valid), 32'd0);

        // second fill from shifted pointers, drained at one per clock
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ic_cmd_in = 2'b01; ic_add_in = 26'h400 + 26'(i);
            step();
        end
        idle_inputs();
        chk("t4_no_drop", drops, 32'd3);
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_drain%0d_addr", i), 32'(mem_add_out), 32'h400 + 32'(i));
            step();
        end
        chk("t4_drained", 32'(mem_valid), 32'd0);
        chk("t4_reqs", reqs, 32'd17);

        // reset with entries queued and a DC request on the reset edge
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ic_cmd_in = 2'b01; ic_add_in = 26'h500 + 26'(i);
            step();
        end
        ic_cmd_in = 2'b00;
        dc_cmd_in = 2'b01; dc_add_in = 26'h555;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle_inputs();
        chk("t5_valid", 32'(mem_valid), 32'd0);
        chk("t5_reqs",  reqs, 32'd0);
        chk("t5_drops", drops, 32'd0);
        chk("t5_merges", merges, 32'd0);
        step();
        chk("t5_still_empty", 32'(mem_valid), 32'd0);

        // back-to-back reads to the same line
        do_reset();
        ic_cmd_in = 2'b01; ic_add_in = 26'h40;
        step();
        ic_cmd_in = 2'b00;
        dc_cmd_in = 2'b01; dc_add_in = 26'h40;
        step();
        idle_inputs();
`ifdef NLQ_MERGE_EN
        chk("t6_reqs",   reqs, 32'd1);
        chk("t6_merges", merges, 32'd1);
`else
        chk("t6_reqs",   reqs, 32'd2);
        chk("t6_merges", merges, 32'd0);
`endif
        mem_ready = 1'b1;
        step();
`ifdef NLQ_MERGE_EN
        chk("t6_after_pop_valid", 32'(mem_valid), 32'd0);
`else
        chk("t6_after_pop_valid", 32'(mem_valid), 32'd1);
        chk("t6_after_pop_addr",  32'(mem_add_out), 32'h40);
`endif
        chk("t6_drops", drops, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
